// File: rtl/sayac_pkg.sv
// sayac_pkg: FSM states and seven-segment codes shared by the counter display.
package sayac_pkg;
  typedef enum logic [1:0] {BOSTA, DONUSTUR, GUNCELLE} durum_t;
  localparam logic [6:0] BOS_KOD = 7'b1111111;
  localparam logic [6:0] SEG_KOD [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/yedi_segment_kod.sv
// yedi_segment_kod: BCD digit to active-low {g,f,e,d,c,b,a} segment pattern.
module yedi_segment_kod
  import sayac_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = bcd > 4'd9 ? BOS_KOD : SEG_KOD[bcd];
endmodule

// File: rtl/sayac_gosterge.sv
// sayac_gosterge: converts a 6-bit count to BCD and multiplexes two 7-segment digits.
module sayac_gosterge
  import sayac_pkg::*;
#(
  parameter int TARAMA_BOLEN = 100000
) (
  input  logic       clk,
  input  logic       sifirlama_n,
  input  logic [5:0] sayi_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       mesgul
);
  localparam int TW = TARAMA_BOLEN > 1 ? $clog2(TARAMA_BOLEN) : 1;
  durum_t durum;
  logic [5:0] onceki_deger;
  logic [3:0] birler, onlar;
  logic [13:0] bcd;
  logic [2:0] adim;
  logic [TW-1:0] tarama;
  logic slot;
  logic [13:0] bcd_duz;
  logic [3:0] kod_in;
  logic [6:0] kod;
  // add-3 correction applied to both BCD nibbles ahead of the shift
  assign bcd_duz = {bcd[13:10] >= 4'd5 ? bcd[13:10] + 4'd3 : bcd[13:10],
                    bcd[9:6] >= 4'd5 ? bcd[9:6] + 4'd3 : bcd[9:6],
                    bcd[5:0]};
  assign kod_in = slot ? onlar : birler;
  assign mesgul = durum != BOSTA;
  assign dp = 1'b1;
  yedi_segment_kod u_kod (.bcd(kod_in), .seg(kod));
  always_ff @(posedge clk) begin
    if (!sifirlama_n) begin
      durum <= BOSTA;
      onceki_deger <= '0;
      birler <= '0;
      onlar <= '0;
      bcd <= '0;
      adim <= '0;
    end else begin
      case (durum)
        BOSTA: if (sayi_in != onceki_deger) begin
          onceki_deger <= sayi_in;
          bcd <= {8'd0, sayi_in};
          adim <= '0;
          durum <= DONUSTUR;
        end
        DONUSTUR: begin
          bcd <= {bcd_duz[12:0], 1'b0};
          adim <= adim + 3'd1;
          if (adim == 3'd5) durum <= GUNCELLE;
        end
        default: begin
          birler <= bcd[9:6];
          onlar <= bcd[13:10];
          durum <= BOSTA;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!sifirlama_n) begin
      tarama <= '0;
      slot <= 1'b0;
      seg <= BOS_KOD;
      an <= 4'b1111;
    end else begin
      tarama <= tarama == TW'(TARAMA_BOLEN - 1) ? '0 : tarama + 1'b1;
      if (tarama == TW'(TARAMA_BOLEN - 1)) slot <= ~slot;
      seg <= kod;
      an <= slot ? (onlar == 4'd0 ? 4'b1111 : 4'b1101) : 4'b1110;
    end
  end
endmodule

// File: tb/tb_sayac_gosterge.sv
// tb_sayac_gosterge: directed checks of conversion latency, digit display and scan timing.
module tb_sayac_gosterge;
  logic clk = 1'b0;
  logic sifirlama_n = 1'b0;
  logic [5:0] sayi_in = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp, mesgul;
  int compared = 0, mismatched = 0;
  logic [6:0] u_seg, t_seg;
  logic u_seen, t_seen, bad_an;

  sayac_gosterge #(.TARAMA_BOLEN(4)) dut (
    .clk(clk), .sifirlama_n(sifirlama_n), .sayi_in(sayi_in),
    .seg(seg), .an(an), .dp(dp), .mesgul(mesgul)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // observes both scan slots over more than one full period
  task automatic capture();
    u_seen = 0; t_seen = 0; bad_an = 0; u_seg = 'x; t_seg = 'x;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (an == 4'b1110) begin u_seen = 1; u_seg = seg; end
      else if (an == 4'b1101) begin t_seen = 1; t_seg = seg; end
      else if (an != 4'b1111) bad_an = 1;
    end
  endtask

  task automatic test_reset();
    sifirlama_n = 0; sayi_in = 0;
    ticks(2);
    compared++; if (an !== 4'b1111) begin mismatched++; $display("FAIL reset_an got=%b exp=1111", an); end
    compared++; if (seg !== 7'b1111111) begin mismatched++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
    compared++; if (mesgul !== 1'b0) begin mismatched++; $display("FAIL reset_mesgul got=%b exp=0", mesgul); end
    compared++; if (dp !== 1'b1) begin mismatched++; $display("FAIL reset_dp got=%b exp=1", dp); end
    sifirlama_n = 1;
    capture();
    compared++; if (!u_seen || u_seg !== 7'b1000000) begin mismatched++; $display("FAIL zero_units seen=%b got=%b exp=1000000", u_seen, u_seg); end
    compared++; if (t_seen || bad_an) begin mismatched++; $display("FAIL zero_tens_blank seen=%b bad=%b exp=0/0", t_seen, bad_an); end
    compared++; if (mesgul !== 1'b0) begin mismatched++; $display("FAIL zero_no_conv got=%b exp=0", mesgul); end
  endtask

  task automatic test_max();
    sayi_in = 63;
    for (int e = 1; e <= 7; e++) begin
      tick();
      compared++; if (mesgul !== 1'b1) begin mismatched++; $display("FAIL max_mesgul edge=%0d got=%b exp=1", e, mesgul); end
    end
    compared++; if (dut.birler !== 4'd0) begin mismatched++; $display("FAIL max_hold got=%0d exp=0", dut.birler); end
    tick();
    compared++; if (mesgul !== 1'b0) begin mismatched++; $display("FAIL max_done got=%b exp=0", mesgul); end
    compared++; if ({dut.onlar, dut.birler} !== 8'h63) begin mismatched++; $display("FAIL max_digits got=%h exp=63", {dut.onlar, dut.birler}); end
    capture();
    compared++; if (u_seg !== 7'b0110000) begin mismatched++; $display("FAIL max_units got=%b exp=0110000", u_seg); end
    compared++; if (!t_seen || t_seg !== 7'b0000010) begin mismatched++; $display("FAIL max_tens seen=%b got=%b exp=0000010", t_seen, t_seg); end
  endtask

  task automatic test_blank();
    sayi_in = 7;
    ticks(8);
    capture();
    compared++; if (u_seg !== 7'b1111000) begin mismatched++; $display("FAIL seven_units got=%b exp=1111000", u_seg); end
    compared++; if (t_seen || bad_an) begin mismatched++; $display("FAIL seven_blank seen=%b bad=%b exp=0/0", t_seen, bad_an); end
  endtask

  task automatic test_back_to_back();
    sayi_in = 12;
    ticks(2);
    sayi_in = 45;
    ticks(6);
    compared++; if ({dut.onlar, dut.birler} !== 8'h12) begin mismatched++; $display("FAIL b2b_first got=%h exp=12", {dut.onlar, dut.birler}); end
    compared++; if (mesgul !== 1'b0) begin mismatched++; $display("FAIL b2b_idle got=%b exp=0", mesgul); end
    tick();
    compared++; if (mesgul !== 1'b1) begin mismatched++; $display("FAIL b2b_restart got=%b exp=1", mesgul); end
    ticks(6);
    compared++; if ({dut.onlar, dut.birler} !== 8'h12) begin mismatched++; $display("FAIL b2b_stable got=%h exp=12", {dut.onlar, dut.birler}); end
    tick();
    compared++; if ({dut.onlar, dut.birler} !== 8'h45) begin mismatched++; $display("FAIL b2b_second got=%h exp=45", {dut.onlar, dut.birler}); end
    capture();
    compared++; if (u_seg !== 7'b0010010 || t_seg !== 7'b0011001) begin mismatched++; $display("FAIL b2b_display got=%b/%b exp=0011001/0010010", t_seg, u_seg); end
  endtask

  task automatic test_reset_abort();
    sayi_in = 12;
    ticks(8);
    sayi_in = 40;
    ticks(3);
    sifirlama_n = 0;
    tick();
    compared++; if (mesgul !== 1'b0 || {dut.onlar, dut.birler} !== 8'h00) begin mismatched++; $display("FAIL abort got=%b/%h exp=0/00", mesgul, {dut.onlar, dut.birler}); end
    compared++; if (an !== 4'b1111) begin mismatched++; $display("FAIL abort_an got=%b exp=1111", an); end
    sifirlama_n = 1;
    tick();
    compared++; if (mesgul !== 1'b1) begin mismatched++; $display("FAIL abort_restart got=%b exp=1", mesgul); end
    ticks(7);
    compared++; if ({dut.onlar, dut.birler} !== 8'h40) begin mismatched++; $display("FAIL abort_digits got=%h exp=40", {dut.onlar, dut.birler}); end
    capture();
    compared++; if (u_seg !== 7'b1000000 || t_seg !== 7'b0011001) begin mismatched++; $display("FAIL abort_display got=%b/%b exp=0011001/1000000", t_seg, u_seg); end
  endtask

  task automatic test_scan();
    logic [3:0] s [0:19];
    int first;
    for (int i = 0; i < 20; i++) begin tick(); s[i] = an; end
    first = -1;
    for (int i = 1; i < 20; i++) if (first < 0 && s[i] != s[i-1]) first = i;
    compared++; if (first < 1 || first > 4) begin mismatched++; $display("FAIL scan_first_toggle got=%0d exp=1..4", first); end
    else
      for (int i = first; i < 20; i++) begin
        compared++;
        if (s[i] !== ((((i - first) / 4) % 2 == 0) ? s[first] : s[first] ^ 4'b0011)
            || (s[i] !== 4'b1110 && s[i] !== 4'b1101)) begin
          mismatched++; $display("FAIL scan cycle=%0d got=%b", i, s[i]);
        end
      end
  endtask

  initial begin
    test_reset();
    test_max();
    test_blank();
    test_back_to_back();
    test_reset_abort();
    test_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sayac_gosterge.md
SAYAC_GOSTERGE -- requirements
Module: sayac_gosterge

Interface
REQ-001 SHALL have parameter TARAMA_BOLEN, default 100000: clk cycles each digit is held lit per scan slot.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port sifirlama_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port sayi_in, input, 6 bits: unsigned counter value to display, 0..63, driven by the upstream slow counter.
REQ-005 SHALL have port seg, output, 7 bits: segment drive, active-low, ordered {g,f,e,d,c,b,a}.
REQ-006 SHALL have port an, output, 4 bits: digit anodes, active-low; an[0] is units, an[1] is tens, an[3:2] always 1.
REQ-007 SHALL have port dp, output, 1 bit: decimal point, constant 1 (off).
REQ-008 SHALL have port mesgul, output, 1 bit: 1 while a conversion is in progress.

Function
REQ-009 SHALL register sayi_in into onceki_deger when a conversion starts, and start a conversion when the FSM is in BOSTA and sayi_in != onceki_deger.
REQ-010 SHALL implement FSM states BOSTA, DONUSTUR and GUNCELLE.
REQ-011 SHALL follow these transitions: BOSTA->DONUSTUR on a detected change; DONUSTUR->GUNCELLE after exactly 6 shift steps; GUNCELLE->BOSTA unconditionally.
REQ-012 SHALL convert binary to BCD by shift-add-3 (double dabble) on a 14-bit register: before each shift, add 3 to each 4-bit BCD nibble that is >=5.
REQ-013 SHALL use this latency, counting the edge that samples the change as edge 1: edge 1 latches and enters DONUSTUR; edges 2-7 perform the shifts; edge 8 writes the birler/onlar registers and returns to BOSTA.
REQ-014 SHALL drive mesgul=1 exactly when the state != BOSTA.
REQ-015 SHALL ignore sayi_in changes while mesgul=1; after returning to BOSTA, a value still differing from onceki_deger SHALL start a new conversion on the next edge.
REQ-016 SHALL hold the displayed digits stable during a conversion; the digits update only in GUNCELLE.
REQ-017 SHALL use a scan counter that counts 0..TARAMA_BOLEN-1 and wraps; each wrap toggles the active slot between units and tens.
REQ-018 SHALL drive an=4'b1110 with seg=code(birler) in the units slot.
REQ-019 SHALL drive an=4'b1101 with seg=code(onlar) in the tens slot, except when onlar==0, where an=4'b1111 (leading-zero blanking).
REQ-020 SHALL use these segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 SHALL output seg=1111111 for any BCD nibble >9 (unreachable; defensive).
REQ-022 SHALL register seg and an; the outputs change only on the clock edge following a slot toggle.

Reset
REQ-023 SHALL apply on sifirlama_n=0 at a rising edge: state=BOSTA, onceki_deger=0, birler=0, onlar=0, BCD register=0, step counter=0, scan counter=0, slot=units, seg=1111111, an=1111, mesgul=0.
REQ-024 SHALL abort any conversion in progress on reset, without updating the digits.
REQ-025 SHALL give reset priority over all other activity.
REQ-026 SHALL display "0" on the units digit from the first scan after reset when sayi_in stays 0, with no conversion started.

Structure
REQ-027 SHALL place the FSM state encodings, the segment code constants and the blank code in a shared package/include sayac_pkg.
REQ-028 SHALL implement the BCD-to-7-segment decode as one combinational sub-module, yedi_segment_kod (4-bit in, 7-bit out).
REQ-029 SHALL keep the double-dabble datapath and the scan multiplexer in sayac_gosterge.

Verification (TARAMA_BOLEN=4 in simulation)
REQ-030 SHALL cover: reset asserted for 2 cycles -> an=1111, seg=1111111, mesgul=0; after release with sayi_in=0 -> units slot shows seg=1000000 and tens slot an=1111.
REQ-031 SHALL cover: sayi_in 0->63 -> mesgul high for edges 1-7, digits 6/3 after edge 8; units slot seg=0110000, tens slot an=1101 with seg=0000010.
REQ-032 SHALL cover: sayi_in=7 -> tens slot an=1111 (blanked); units slot seg=1111000.
REQ-033 SHALL cover: sayi_in=12, then 45 on edge 3 of the conversion -> digits show 1/2 after edge 8, then 4/5 after 8 further edges.
REQ-034 SHALL cover: sayi_in 12->40 with sifirlama_n low on edge 4 of the conversion -> digits 0/0, state BOSTA; after release -> a new conversion yields 4/0.
REQ-035 SHALL cover scan timing: slot toggles every 4 cycles; an alternates between 1110 and 1101 (for a value >=10) with no overlap and no cycle with both digits lit.
